// File: rtl/cc1200_pkg.sv
// Shared types and constants for the CC1200 register-access sequencer.
// Header byte layout: [7]=read, [6]=burst, [5:0]=address.
package cc1200_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAITHI,
    ST_WAITLO,
    ST_NEXT,
    ST_STOP,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    PH_HDR,
    PH_EXT,
    PH_DATA
  } phase_e;

  localparam logic [7:0] EXT_ADDR  = 8'h2F;
  localparam int         RW_BIT    = 7;
  localparam int         BURST_BIT = 6;
  localparam logic [7:0] STROBE_LO = 8'h30;
  localparam logic [7:0] STROBE_HI = 8'h3D;

  function automatic logic [7:0] make_header(input logic rd, input logic burst,
                                             input logic [5:0] addr6);
    logic [7:0] h;
    h            = {2'b00, addr6};
    h[RW_BIT]    = rd;
    h[BURST_BIT] = burst;
    return h;
  endfunction

endpackage

// File: rtl/cc1200_byte_xfer.sv
// One-byte handshake with the SPI byte engine: pulse start, wait for busy
// to rise, then for busy to fall; xfer_done marks the cycle the rx byte is valid.
module cc1200_byte_xfer
  import cc1200_pkg::*;
(
  input  logic        clk,
  input  logic        rstn,
  input  logic        go,
  input  logic [7:0]  tx_byte,
  output logic [7:0]  rx_byte,
  output logic        xfer_done,
  output logic        spi_start,
  input  logic        spi_busy,
  input  logic [7:0]  spi_din_lo,
  output logic [31:0] spi_dout
);

  state_e     state_q;
  logic       start_q;
  logic [7:0] dout_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      dout_q  <= 8'h00;
    end else begin
      start_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (go) begin
          dout_q  <= tx_byte;
          start_q <= 1'b1;
          state_q <= ST_ISSUE;
        end
        ST_ISSUE:  state_q <= ST_WAITHI;
        ST_WAITHI: if (spi_busy) state_q <= ST_WAITLO;
        ST_WAITLO: if (!spi_busy) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign xfer_done = (state_q == ST_WAITLO) && !spi_busy;
  assign rx_byte   = spi_din_lo;
  assign spi_start = start_q;
  assign spi_dout  = {24'h000000, dout_q};

endmodule

// File: rtl/cc1200_access_seq.sv
// Turns one register-access request into the CC1200 byte sequence
// (header, optional extended address, data) and streams read bytes out.
module cc1200_access_seq
  import cc1200_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_read,
  input  logic [15:0]      req_addr,
  input  logic [LEN_W-1:0] req_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [7:0]       wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [7:0]       rd_data,
  output logic             spi_start,
  output logic             spi_stop,
  input  logic             spi_busy,
  output logic [31:0]      spi_dout,
  input  logic [31:0]      spi_din,
  output logic [7:0]       status,
  output logic             done,
  output logic             err
);

  state_e           state_q;
  phase_e           phase_q;
  logic             read_q, ext_q;
  logic [7:0]       addr_lo_q;
  logic [LEN_W-1:0] remain_q;
  logic [7:0]       status_q, rd_data_q;
  logic             rd_valid_q, spi_stop_q, done_q, err_q;

  logic       accept, req_ok, req_ext, go, xfer_done, ext_pending;
  logic [7:0] tx_byte, rx_byte;
  logic       unused_din;

  assign unused_din  = ^spi_din[31:8];
  assign accept      = req_valid && (state_q == ST_IDLE);
  assign req_ext     = (req_addr[15:8] == EXT_ADDR);
  assign req_ok      = (req_ext || (req_addr[15:8] == 8'h00)) &&
                       (req_len <= LEN_W'(MAX_LEN));
  assign ext_pending = (phase_q == PH_HDR) && ext_q;

  // Byte selection; a read data byte waits until the previous one is taken.
  always_comb begin
    go       = 1'b0;
    tx_byte  = 8'h00;
    wr_ready = 1'b0;
    case (state_q)
      ST_IDLE: if (accept && req_ok) begin
        go      = 1'b1;
        tx_byte = make_header(req_read, req_len > LEN_W'(1),
                              req_ext ? EXT_ADDR[5:0] : req_addr[5:0]);
      end
      ST_NEXT: begin
        if (ext_pending) begin
          go      = 1'b1;
          tx_byte = addr_lo_q;
        end else if (remain_q != '0) begin
          if (read_q) begin
            go = !(rd_valid_q && !rd_ready);
          end else if (wr_valid) begin
            go       = 1'b1;
            tx_byte  = wr_data;
            wr_ready = 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= ST_IDLE;
      phase_q    <= PH_HDR;
      read_q     <= 1'b0;
      ext_q      <= 1'b0;
      addr_lo_q  <= 8'h00;
      remain_q   <= '0;
      status_q   <= 8'h00;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
      spi_stop_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      spi_stop_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      if (rd_valid_q && rd_ready) rd_valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: if (accept) begin
          if (req_ok) begin
            read_q    <= req_read;
            ext_q     <= req_ext;
            addr_lo_q <= req_addr[7:0];
            remain_q  <= req_len;
            phase_q   <= PH_HDR;
            state_q   <= ST_ISSUE;
          end else begin
            err_q <= 1'b1;
          end
        end
        // Waiting on the byte engine; only the header exchange sets status.
        ST_ISSUE: if (xfer_done) begin
          if (phase_q == PH_HDR) begin
            status_q <= rx_byte;
          end else if ((phase_q == PH_DATA) && read_q) begin
            rd_data_q  <= rx_byte;
            rd_valid_q <= 1'b1;
          end
          state_q <= ST_NEXT;
        end
        ST_NEXT: begin
          if (go) begin
            state_q <= ST_ISSUE;
            if (ext_pending) begin
              phase_q <= PH_EXT;
            end else begin
              phase_q  <= PH_DATA;
              remain_q <= remain_q - LEN_W'(1);
            end
          end else if (!ext_pending && (remain_q == '0)) begin
            spi_stop_q <= 1'b1;
            state_q    <= ST_STOP;
          end
        end
        ST_STOP: begin
          done_q  <= 1'b1;
          state_q <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  cc1200_byte_xfer u_xfer (
    .clk        (clk),
    .rstn       (rstn),
    .go         (go),
    .tx_byte    (tx_byte),
    .rx_byte    (rx_byte),
    .xfer_done  (xfer_done),
    .spi_start  (spi_start),
    .spi_busy   (spi_busy),
    .spi_din_lo (spi_din[7:0]),
    .spi_dout   (spi_dout)
  );

  assign req_ready = (state_q == ST_IDLE);
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign spi_stop  = spi_stop_q;
  assign status    = status_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
